alu_sequencer: RTL and testbench

//  Sequential front end of the ALU, directly upstream of MUX. Accepts one instruction
//  {opcode, operand} per valid/ready handshake and holds an 8-bit accumulator.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_sequencer.sv | 114 +++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: opcode values used by both the
// sequencer and the MUX select decode, and the sequencer FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_INV  = 4'd6;
  localparam logic [3:0] OP_SL   = 4'd7;
  localparam logic [3:0] OP_SR   = 4'd8;
  localparam logic [3:0] OP_LOAD = 4'd9;

  // Highest opcode the sequencer accepts; anything above is reported as illegal.
  localparam logic [3:0] OP_LAST_LEGAL = OP_LOAD;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequential front end of the ALU: accepts one instruction per handshake,
// issues it to the external ALU units/MUX for one cycle, writes the MUX
// result back into the accumulator and returns the accumulator as a response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [WIDTH-1:0] in_operand,
  output logic [OPW-1:0]   opS,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  state_t           state_q, state_d;
  logic [OPW-1:0]   opcode_q, opcode_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             err_q, err_d;

  // State, instruction latch, accumulator and error flag registers.
  // NOTE: every register, including the instruction latch, is reset so a
  // reset mid-operation discards the pending instruction cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: capture in IDLE, write back at the end of ISSUE,
  // hold the response in RESP until the consumer takes it.
  // NOTE: every _d signal is defaulted to its _q first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opcode_d  = in_opcode;
          operand_d = in_operand;
          if (is_legal(in_opcode)) begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            // Illegal opcodes skip the ALU entirely; acc is preserved.
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (opcode_q == OP_LOAD) begin
          acc_d = operand_q;
        end else if (opcode_q != OP_NOP) begin
          acc_d = alu_result;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: operands only reach the ALU during ISSUE; outside it the
  // MUX sees NOP and its result is ignored.
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    opS       = OP_NOP;
    op_a      = acc_q;
    op_b      = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_zero  = 1'b0;
    out_err   = 1'b0;
    if (state_q == S_ISSUE) begin
      opS  = (opcode_q == OP_LOAD) ? OP_NOP : opcode_q;
      op_b = operand_q;
    end
    if (state_q == S_RESP) begin
      out_valid = 1'b1;
      out_data  = acc_q;
      out_zero  = (acc_q == '0);
      out_err   = err_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: the ALU units and MUX are modelled combinationally
// here, and an accumulator reference model predicts every response.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_operand;
  logic [3:0] opS;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] acc_m = 8'h00;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_operand (in_operand),
    .opS        (opS),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  // External ALU units plus MUX, selected by opS.
  always_comb begin
    case (opS)
      4'd1:    alu_result = op_a + op_b;
      4'd2:    alu_result = op_a - op_b;
      4'd3:    alu_result = op_a & op_b;
      4'd4:    alu_result = op_a | op_b;
      4'd5:    alu_result = op_a ^ op_b;
      4'd6:    alu_result = ~op_a;
      4'd7:    alu_result = op_a << 1;
      4'd8:    alu_result = op_a >> 1;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Reference: accumulator value after one instruction, in plain integer arithmetic.
  function automatic logic [7:0] model_acc(input logic [7:0] a, input logic [3:0] op, input logic [7:0] b);
    int ai = a;
    int bi = b;
    int r;
    case (op)
      4'd0:    r = ai;
      4'd1:    r = ai + bi;
      4'd2:    r = ai - bi + 256;
      4'd3:    r = ai & bi;
      4'd4:    r = ai | bi;
      4'd5:    r = ai ^ bi;
      4'd6:    r = 255 - ai;
      4'd7:    r = ai * 2;
      4'd8:    r = ai / 2;
      4'd9:    r = bi;
      default: r = ai;
    endcase
    return 8'(r % 256);
  endfunction

  // One instruction: handshake, watch the issue cycle, check the response,
  // optionally stall in RESP for 'hold' cycles, then optionally release it.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] opnd, input int hold, input bit complete);
    bit         got;
    int         lat;
    bit         illegal;
    logic [7:0] exp_acc;
    logic [3:0] exp_ops;
    illegal = (op > 4'd9);
    exp_acc = model_acc(acc_m, op, opnd);
    exp_ops = (op == 4'd9) ? 4'd0 : op;

    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    check("in_ready_wait", got, 1);
    if (!got) return;

    in_valid   = 1'b1;
    in_opcode  = op;
    in_operand = opnd;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_opcode  = 4'($urandom);
    in_operand = 8'($urandom);

    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
      else begin
        check("issue_opS", opS, exp_ops);
        check("issue_op_a", op_a, acc_m);
        check("issue_op_b", op_b, opnd);
      end
    end
    check("latency", lat, illegal ? 1 : 2);
    acc_m = exp_acc;
    check("out_data", out_data, exp_acc);
    check("out_zero", out_zero, exp_acc == 8'h00);
    check("out_err", out_err, illegal);
    check("resp_in_ready", in_ready, 0);
    check("resp_opS", opS, 0);

    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'($urandom);
      in_opcode  = 4'($urandom);
      in_operand = 8'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_acc);
      check("hold_zero", out_zero, exp_acc == 8'h00);
      check("hold_err", out_err, illegal);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    if (!complete) return;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("released_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = 4'd0;
    in_operand = 8'd0;
    out_ready  = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_err", out_err, 0);
    check("rst_opS", opS, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_a", op_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed sequence.
    run_instr(4'd9, 8'h05, 0, 1);   // LOAD 0x05
    run_instr(4'd1, 8'h03, 0, 1);   // ADD  -> 0x08
    run_instr(4'd2, 8'h08, 0, 1);   // SUB  -> 0x00, zero
    run_instr(4'd2, 8'h01, 0, 1);   // SUB  -> 0xFF wrap
    run_instr(4'd9, 8'h81, 0, 1);
    run_instr(4'd7, 8'h00, 0, 1);   // SL   -> 0x02
    run_instr(4'd8, 8'h00, 0, 1);   // SR   -> 0x01
    run_instr(4'd9, 8'h0F, 0, 1);
    run_instr(4'd6, 8'h00, 0, 1);   // INV  -> 0xF0
    run_instr(4'd9, 8'h0F, 0, 1);
    run_instr(4'd5, 8'hAA, 0, 1);   // XOR  -> 0xA5
    run_instr(4'd9, 8'h33, 0, 1);
    run_instr(4'hC, 8'h77, 0, 1);   // illegal -> err, 0x33
    run_instr(4'd0, 8'h12, 5, 1);   // NOP, err cleared, 5-cycle stall

    // Reset while a response is pending.
    run_instr(4'd9, 8'h08, 0, 0);
    check("pre_rst_acc", op_a, 8'h08);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_acc", op_a, 0);
    check("midrst_out_data", out_data, 0);
    acc_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    check("postrst_out_valid", out_valid, 0);

    // Randomised instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
